// File: rtl/pcs_pkg.sv
// Shared 10GBASE-R PCS constants and helpers for the receive path.
package pcs_pkg;

    localparam int          BLOCK_W   = 66;
    localparam int          HDR_W     = 2;
    localparam logic [1:0]  SYNC_DATA = 2'b01;
    localparam logic [1:0]  SYNC_CTRL = 2'b10;
    localparam int          SLIP_MOD  = 66;

    // Number of payload words of width dw that make up one 66-bit block.
    function automatic int words_per_block(input int dw);
        return (BLOCK_W - HDR_W) / dw;
    endfunction

endpackage

// File: rtl/rx_gearbox_66b.sv
// RX gearbox: reassembles 66-bit blocks from a raw LSB-first transceiver
// stream and emits them as 64/DATA_WIDTH payload words, with the sync header
// attached to the first word of each block. Alignment can be advanced one bit
// at a time through i_slip.
module rx_gearbox_66b
    import pcs_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int HDR_WIDTH  = 2,
    parameter int BUF_WIDTH  = 2*DATA_WIDTH+4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    input  logic                  i_slip,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [HDR_WIDTH-1:0]  o_hdr,
    output logic                  o_hdr_valid,
    output logic                  o_valid,
    output logic                  o_slip_busy,
    output logic [6:0]            o_slip_cnt
);

    localparam int WPB    = words_per_block(DATA_WIDTH);
    localparam int FILL_W = $clog2(BUF_WIDTH+1);
    localparam int IDX_W  = 2;

    logic [BUF_WIDTH-1:0]  buf_q,  buf_d;
    logic [FILL_W-1:0]     fill_q, fill_d;
    logic [IDX_W-1:0]      word_idx_q, word_idx_d;
    logic                  slip_pend_q, slip_pend_d;
    logic [6:0]            slip_cnt_q, slip_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [HDR_WIDTH-1:0]  hdr_q, hdr_d;
    logic                  valid_q, valid_d;
    logic                  hdr_valid_q, hdr_valid_d;

    // Working values of the combinational step.
    logic [BUF_WIDTH-1:0]  acc_comb;
    logic [BUF_WIDTH-1:0]  hdr_sh;
    logic [BUF_WIDTH-1:0]  data_sh;
    logic [FILL_W-1:0]     total;
    logic [FILL_W-1:0]     need;

    // Merge new word into the accumulator, extract one output word when
    // enough bits are present, and track slip requests.
    always_comb begin
        buf_d       = buf_q;
        fill_d      = fill_q;
        word_idx_d  = word_idx_q;
        slip_pend_d = slip_pend_q;
        slip_cnt_d  = slip_cnt_q;
        data_d      = data_q;
        hdr_d       = hdr_q;
        valid_d     = 1'b0;
        hdr_valid_d = 1'b0;

        if (i_rx_valid) begin
            acc_comb = buf_q | (BUF_WIDTH'(i_rx_data) << fill_q);
            total    = fill_q + FILL_W'(DATA_WIDTH);
        end else begin
            acc_comb = buf_q;
            total    = fill_q;
        end

        // A pending slip makes the first word of a block swallow one extra
        // bit ahead of the header, moving the block boundary by +1.
        if (word_idx_q == '0) begin
            need = FILL_W'(DATA_WIDTH + HDR_WIDTH) + FILL_W'(slip_pend_q);
        end else begin
            need = FILL_W'(DATA_WIDTH);
        end

        hdr_sh  = acc_comb >> slip_pend_q;
        data_sh = acc_comb >> (FILL_W'(HDR_WIDTH) + FILL_W'(slip_pend_q));

        if (total >= need) begin
            buf_d   = acc_comb >> need;
            fill_d  = total - need;
            valid_d = 1'b1;
            if (word_idx_q == '0) begin
                hdr_d       = hdr_sh[HDR_WIDTH-1:0];
                data_d      = data_sh[DATA_WIDTH-1:0];
                hdr_valid_d = 1'b1;
                if (slip_pend_q) begin
                    slip_pend_d = 1'b0;
                    slip_cnt_d  = (slip_cnt_q == 7'(SLIP_MOD-1)) ? 7'd0 : slip_cnt_q + 7'd1;
                end
            end else begin
                data_d = acc_comb[DATA_WIDTH-1:0];
            end
            word_idx_d = (word_idx_q == IDX_W'(WPB-1)) ? '0 : word_idx_q + IDX_W'(1);
        end else begin
            buf_d  = acc_comb;
            fill_d = total;
        end

        // New requests are taken only when none is outstanding; a request
        // that arrives on a header emit lands on the following block.
        if (i_slip && !slip_pend_q) begin
            slip_pend_d = 1'b1;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            buf_q       <= '0;
            fill_q      <= '0;
            word_idx_q  <= '0;
            slip_pend_q <= 1'b0;
            slip_cnt_q  <= '0;
            data_q      <= '0;
            hdr_q       <= '0;
            valid_q     <= 1'b0;
            hdr_valid_q <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            fill_q      <= fill_d;
            word_idx_q  <= word_idx_d;
            slip_pend_q <= slip_pend_d;
            slip_cnt_q  <= slip_cnt_d;
            data_q      <= data_d;
            hdr_q       <= hdr_d;
            valid_q     <= valid_d;
            hdr_valid_q <= hdr_valid_d;
        end
    end

    assign o_data      = data_q;
    assign o_hdr       = hdr_q;
    assign o_valid     = valid_q;
    assign o_hdr_valid = hdr_valid_q;
    assign o_slip_busy = slip_pend_q;
    assign o_slip_cnt  = slip_cnt_q;

    // The accumulator never overflows: fill stays below the buffer width.
    a_fill_bound: assert property (@(posedge i_clk) disable iff (!i_reset_n)
                                   fill_q < FILL_W'(BUF_WIDTH));

endmodule

// File: tb/tb_rx_gearbox_66b.sv
// Bench for rx_gearbox_66b: three widths (16/32/64) run side by side, each
// fed from the same block stream and checked every cycle against a bit-queue
// reference model, plus directed checks on first block, throughput and slip.
module tb_rx_gearbox_66b;
    import pcs_pkg::*;

    localparam int NB  = 256;
    localparam int SBN = 8192;

    logic        clk;
    logic        rst_n;
    logic        rx_valid;
    logic        slip;
    logic [15:0] rx16, od16;
    logic [31:0] rx32, od32;
    logic [63:0] rx64, od64;
    logic [1:0]  oh16, oh32, oh64;
    logic        hv16, hv32, hv64, v16, v32, v64, b16, b32, b64;
    logic [6:0]  c16, c32, c64;

    rx_gearbox_66b #(.DATA_WIDTH(16)) dut16 (
        .i_clk(clk), .i_reset_n(rst_n), .i_rx_data(rx16), .i_rx_valid(rx_valid),
        .i_slip(slip), .o_data(od16), .o_hdr(oh16), .o_hdr_valid(hv16),
        .o_valid(v16), .o_slip_busy(b16), .o_slip_cnt(c16));
    rx_gearbox_66b #(.DATA_WIDTH(32)) dut32 (
        .i_clk(clk), .i_reset_n(rst_n), .i_rx_data(rx32), .i_rx_valid(rx_valid),
        .i_slip(slip), .o_data(od32), .o_hdr(oh32), .o_hdr_valid(hv32),
        .o_valid(v32), .o_slip_busy(b32), .o_slip_cnt(c32));
    rx_gearbox_66b #(.DATA_WIDTH(64)) dut64 (
        .i_clk(clk), .i_reset_n(rst_n), .i_rx_data(rx64), .i_rx_valid(rx_valid),
        .i_slip(slip), .o_data(od64), .o_hdr(oh64), .o_hdr_valid(hv64),
        .o_valid(v64), .o_slip_busy(b64), .o_slip_cnt(c64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DUT outputs gathered into per-instance arrays (index 0/1/2 = 16/32/64).
    logic [63:0] gd[3];
    logic [1:0]  gh[3];
    logic        gv[3], ghv[3], gb[3];
    logic [6:0]  gc[3];
    always_comb begin
        gd[0] = 64'(od16); gd[1] = 64'(od32); gd[2] = od64;
        gh[0] = oh16;  gh[1] = oh32;  gh[2] = oh64;
        gv[0] = v16;   gv[1] = v32;   gv[2] = v64;
        ghv[0] = hv16; ghv[1] = hv32; ghv[2] = hv64;
        gb[0] = b16;   gb[1] = b32;   gb[2] = b64;
        gc[0] = c16;   gc[1] = c32;   gc[2] = c64;
    end

    // Stream source: line bit p is block bit (p+off); header in block [1:0].
    logic [65:0] blk[NB];
    int          off;
    int          gp[3];

    // Reference model: every received bit goes into a circular bit store;
    // words are taken from it in arrival order following the block rules.
    bit          sb[3][SBN];
    int          wr[3], rd[3], idx[3], pend[3], cnt[3];
    logic [63:0] exp_d[3];
    logic [1:0]  exp_h[3];
    logic        exp_v[3], exp_hv[3];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input int i, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s dw=%0d got=%h exp=%h", tag, 16 << i, got, exp);
        end
    endtask

    function automatic bit gen_bit(input int p);
        int q;
        logic [65:0] b;
        q = p + off;
        b = blk[(q / 66) % NB];
        return b[q % 66];
    endfunction

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk("valid",     i, 64'(gv[i]),  64'(exp_v[i]));
            chk("hdr_valid", i, 64'(ghv[i]), 64'(exp_hv[i]));
            chk("data",      i, gd[i],       exp_d[i]);
            chk("hdr",       i, 64'(gh[i]),  64'(exp_h[i]));
            chk("slip_busy", i, 64'(gb[i]),  64'(pend[i]));
            chk("slip_cnt",  i, 64'(gc[i]),  64'(cnt[i]));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            wr[i] = 0; rd[i] = 0; idx[i] = 0; pend[i] = 0; cnt[i] = 0; gp[i] = 0;
            exp_d[i] = '0; exp_h[i] = '0; exp_v[i] = 1'b0; exp_hv[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        rx_valid = 1'($urandom);
        slip     = 1'($urandom);
        rx16 = 16'($urandom); rx32 = $urandom; rx64 = {$urandom, $urandom};
        model_reset();
        @(posedge clk); #1;
        check_all();
        for (int i = 0; i < 3; i++) begin
            chk("rst_valid", i, 64'(gv[i]), 64'd0);
            chk("rst_data",  i, gd[i],      64'd0);
        end
    endtask

    // One clock: build each width's input word, advance the model, check.
    task automatic step(input bit v, input bit s);
        logic [63:0] w;
        int dw, need, po;
        bit b;
        for (int i = 0; i < 3; i++) begin
            dw = 16 << i;
            w  = '0;
            if (v) begin
                for (int k = 0; k < dw; k++) begin
                    b = gen_bit(gp[i]);
                    gp[i]++;
                    w[k] = b;
                    sb[i][wr[i] % SBN] = b;
                    wr[i]++;
                end
            end
            if (i == 0) rx16 = w[15:0];
            else if (i == 1) rx32 = w[31:0];
            else rx64 = w;

            po   = pend[i];
            need = (idx[i] == 0) ? dw + 2 + po : dw;
            if (wr[i] - rd[i] >= need) begin
                if (idx[i] == 0) begin
                    rd[i] += po;
                    exp_h[i] = {sb[i][(rd[i] + 1) % SBN], sb[i][rd[i] % SBN]};
                    rd[i] += 2;
                    exp_hv[i] = 1'b1;
                    if (po != 0) begin
                        cnt[i]  = (cnt[i] + 1) % SLIP_MOD;
                        pend[i] = 0;
                    end
                end else begin
                    exp_hv[i] = 1'b0;
                end
                exp_d[i] = '0;
                for (int k = 0; k < dw; k++) exp_d[i][k] = sb[i][(rd[i] + k) % SBN];
                rd[i] += dw;
                exp_v[i] = 1'b1;
                idx[i]   = (idx[i] + 1) % words_per_block(dw);
            end else begin
                exp_v[i]  = 1'b0;
                exp_hv[i] = 1'b0;
            end
            if (s && po == 0) pend[i] = 1;
        end
        rst_n    = 1'b1;
        rx_valid = v;
        slip     = s;
        @(posedge clk); #1;
        check_all();
    endtask

    // mode 0: continuous, 1: valid 1010..., 2: random valid and slips.
    task automatic run(input int n, input int mode, output int nv32, output int bad32,
                       output int badall, output int gap64);
        bit v, s;
        nv32 = 0; bad32 = 0; badall = 0; gap64 = 0;
        for (int c = 0; c < n; c++) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ((c % 2) == 0) : 1'($urandom);
            s = (mode == 2) ? ($urandom_range(0, 5) == 0) : 1'b0;
            step(v, s);
            if (gv[1]) nv32++;
            for (int i = 0; i < 3; i++) begin
                if (ghv[i] && gh[i] != SYNC_DATA && gh[i] != SYNC_CTRL) begin
                    badall++;
                    if (i == 1) bad32++;
                end
            end
            if (gv[2] && !ghv[2]) gap64++;
        end
    endtask

    // Pulse i_slip once and wait (bounded) for the 32-bit instance to apply it.
    task automatic slip_once();
        int n;
        step(1'b1, 1'b1);
        n = 0;
        while (gb[1] && n < 300) begin
            step(1'b1, 1'b0);
            n++;
        end
        chk("slip_wait", 1, 64'(gb[1]), 64'd0);
    endtask

    task automatic rand_blocks();
        for (int j = 0; j < NB; j++)
            blk[j] = {$urandom, $urandom, ($urandom_range(0, 1) != 0) ? SYNC_CTRL : SYNC_DATA};
    endtask

    initial begin
        int nv, b32c, ball, g64, c0;
        rst_n = 1'b0; rx_valid = 1'b0; slip = 1'b0;
        rx16 = '0; rx32 = '0; rx64 = '0;
        off = 0;

        // Reset and first block with a fixed payload.
        for (int j = 0; j < NB; j++) blk[j] = {64'h0123_4567_89AB_CDEF, SYNC_DATA};
        do_reset();
        do_reset();
        step(1'b1, 1'b0);
        chk("first_empty", 1, 64'(gv[1]), 64'd0);
        step(1'b1, 1'b0);
        chk("first_valid", 1, 64'(gv[1]),  64'd1);
        chk("first_hv",    1, 64'(ghv[1]), 64'd1);
        chk("first_hdr",   1, 64'(gh[1]),  64'(SYNC_DATA));
        chk("first_data",  1, gd[1],       64'h89AB_CDEF);
        step(1'b1, 1'b0);
        chk("second_data", 1, gd[1],       64'h0123_4567);
        chk("second_hv",   1, 64'(ghv[1]), 64'd0);

        // Steady state: 330 input cycles carry 160 blocks = 320 words.
        run(327, 0, nv, b32c, ball, g64);
        chk("steady_words", 1, 64'(nv + 2), 64'd320);
        chk("steady_hdrs",  1, 64'(ball),   64'd0);

        // Five junk bits ahead of the first block: five slips realign.
        rand_blocks();
        off = 66 - 5;
        do_reset();
        run(20, 0, nv, b32c, ball, g64);
        for (int k = 0; k < 5; k++) slip_once();
        chk("slip5_cnt", 1, 64'(gc[1]), 64'd5);
        run(100, 0, nv, b32c, ball, g64);
        chk("slip5_hdrs", 1, 64'(b32c), 64'd0);

        // Full wrap: 66 slips bring the count and alignment back.
        off = 0;
        do_reset();
        run(10, 0, nv, b32c, ball, g64);
        for (int k = 0; k < 66; k++) slip_once();
        chk("wrap_cnt", 1, 64'(gc[1]), 64'd0);
        run(100, 0, nv, b32c, ball, g64);
        chk("wrap_hdrs", 1, 64'(b32c), 64'd0);

        // Slip while busy is ignored.
        c0 = int'(gc[1]);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        run(8, 0, nv, b32c, ball, g64);
        chk("collide_cnt", 1, 64'(gc[1]), 64'((c0 + 1) % SLIP_MOD));

        // Stalls: alternating valid, then random valid and random slips.
        run(200, 1, nv, b32c, ball, g64);
        run(600, 2, nv, b32c, ball, g64);

        // Mid-block reset, then realignment from the new stream start.
        step(1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            chk("mrst_hv",  i, 64'(ghv[i]), 64'd0);
            chk("mrst_hdr", i, 64'(gh[i]),  64'd0);
            chk("mrst_cnt", i, 64'(gc[i]),  64'd0);
        end
        run(150, 0, nv, b32c, ball, g64);
        chk("mrst_hdrs", 0, 64'(ball), 64'd0);
        chk("dw64_all_hdr", 2, 64'(g64), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
